// File: rtl/product_accumulator.sv
// Sums groups of N_TERMS consecutive valid multiplier products and offers each
// group sum on a valid/ready port, flagging sums dropped while the port is stalled.
module product_accumulator #(
   parameter int PROD_W       = 8,
   parameter int MULT_LATENCY = 3,
   parameter int N_TERMS      = 4,
   parameter int ACC_W        = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [PROD_W-1:0] z,
   input  logic              out_ready,
   input  logic              clr_overrun,
   output logic              out_valid,
   output logic [ACC_W-1:0]  out_sum,
   output logic              overrun,
   output logic              busy
);

   localparam int               CNT_W    = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

   logic [MULT_LATENCY-1:0] vpipe_q, vpipe_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic [ACC_W-1:0]        out_sum_q, out_sum_d;
   logic                    out_valid_q, out_valid_d;
   logic                    overrun_q, overrun_d;

   logic                    prod_v;
   logic [ACC_W-1:0]        z_ext;
   logic [ACC_W-1:0]        sum;

   // The multiplier carries no valid, so in_valid rides a matching delay line.
   assign prod_v = vpipe_q[MULT_LATENCY-1];
   assign z_ext  = ACC_W'(z);
   assign sum    = acc_q + z_ext;

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
      vpipe_d     = vpipe_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_sum_d   = out_sum_q;
      out_valid_d = out_valid_q;
      overrun_d   = overrun_q;

      vpipe_d[0] = in_valid;
      for (int i = 1; i < MULT_LATENCY; i++) begin
         vpipe_d[i] = vpipe_q[i-1];
      end

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // Clear is applied before the completion logic so a same-edge drop wins.
      if (clr_overrun) begin
         overrun_d = 1'b0;
      end

      if (prod_v) begin
         if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            acc_d = '0;
            if (!out_valid_q || out_ready) begin
               out_sum_d   = sum;
               out_valid_d = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = (cnt_q == '0) ? z_ext : sum;
         end
      end
   end

   // NOTE: state updates use non-blocking assignments so all flops sample together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vpipe_q     <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         out_sum_q   <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         vpipe_q     <= vpipe_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_sum_q   <= out_sum_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign overrun   = overrun_q;
   assign busy      = (cnt_q != '0) || (vpipe_q != '0);

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 3-stage multiplier model feeds z, a
// queue holds expected group sums and a monitor checks every accepted output.
module tb_product_accumulator;

   localparam int PROD_W = 8;
   localparam int ACC_W  = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic [PROD_W-1:0] z;
   logic              out_ready;
   logic              clr_overrun;
   logic              out_valid;
   logic [ACC_W-1:0]  out_sum;
   logic              overrun;
   logic              busy;

   logic [3:0]        x_in, y_in;
   logic [PROD_W-1:0] m1, m2;

   int checks   = 0;
   int failures = 0;
   int sb_q[$];

   always #5 clk = ~clk;

   // Multiplier model: operands sampled at edge k, product visible after edge k+2.
   always @(posedge clk) begin
      m1 <= x_in * y_in;
      m2 <= m1;
      z  <= m2;
   end

   product_accumulator #(
      .PROD_W(PROD_W), .MULT_LATENCY(3), .N_TERMS(4), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .z(z),
      .out_ready(out_ready), .clr_overrun(clr_overrun),
      .out_valid(out_valid), .out_sum(out_sum), .overrun(overrun), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; the monitor samples on the falling edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [3:0] x, input logic [3:0] y);
      x_in     = x;
      y_in     = y;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected out_sum=%0d required=none", out_sum);
         end else begin
            check("sb_sum", 32'(out_sum), 32'(sb_q.pop_front()));
         end
      end
   end

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      x_in        = '0;
      y_in        = '0;
      out_ready   = 1'b1;
      clr_overrun = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_sum",   32'(out_sum),   0);
      check("rst_overrun",   32'(overrun),   0);
      check("rst_busy",      32'(busy),      0);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // Back-to-back group with latency and single-cycle out_valid.
      sb_q.push_back(101);
      send(3, 2); send(8, 5); send(4, 7); send(9, 3);
      check("b2b_busy", 32'(busy), 1);
      idle(2);
      check("b2b_valid_k2", 32'(out_valid), 0);
      idle(1);
      check("b2b_valid_k3", 32'(out_valid), 1);
      check("b2b_sum_k3",   32'(out_sum),   101);
      idle(1);
      check("b2b_valid_k4", 32'(out_valid), 0);
      check("b2b_idle_busy", 32'(busy), 0);

      // Same group with gaps, then a fresh group with no carry-over.
      sb_q.push_back(101);
      send(3, 2); idle(2); send(8, 5); idle(1); send(4, 7); idle(3); send(9, 3);
      idle(2);
      sb_q.push_back(115);
      send(3, 4); idle(1); send(6, 8); send(7, 5); idle(2); send(5, 4);
      idle(5);
      check("gap_sum", 32'(out_sum), 115);

      // Stall: second group is dropped and overrun sticks until cleared.
      out_ready = 1'b0;
      sb_q.push_back(101);
      send(3, 2); send(8, 5); send(4, 7); send(9, 3);
      send(3, 4); send(6, 8); send(7, 5); send(5, 4);
      idle(4);
      check("stall_valid",   32'(out_valid), 1);
      check("stall_sum",     32'(out_sum),   101);
      check("stall_overrun", 32'(overrun),   1);
      out_ready = 1'b1;
      tick();
      check("stall_taken_valid", 32'(out_valid), 0);
      check("stall_sticky_ovr",  32'(overrun),   1);
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      check("clr_overrun", 32'(overrun), 0);

      // Maximum products: no overflow of the 10-bit sum.
      sb_q.push_back(900);
      send(15, 15); send(15, 15); send(15, 15); send(15, 15);
      idle(4);
      check("max_sum", 32'(out_sum), 900);

      // Build up held output, overrun and a partial group, then reset mid-group.
      out_ready = 1'b0;
      send(15, 15); send(15, 15); send(15, 15); send(15, 15);
      send(3, 2); send(8, 5); send(4, 7); send(9, 3);
      send(1, 1); send(2, 2);
      idle(4);
      check("pre_rst_valid",   32'(out_valid), 1);
      check("pre_rst_overrun", 32'(overrun),   1);
      check("pre_rst_busy",    32'(busy),      1);
      send(5, 5); send(6, 6);
      check("pre_rst_inflight", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 0);
      check("mid_rst_out_sum",   32'(out_sum),   0);
      check("mid_rst_overrun",   32'(overrun),   0);
      check("mid_rst_busy",      32'(busy),      0);
      idle(2);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      idle(1);

      sb_q.push_back(43);
      send(2, 9); send(6, 4); send(1, 1); send(0, 7);
      idle(4);
      check("post_rst_sum", 32'(out_sum), 43);

      for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
      check("sb_drained", 32'(sb_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
